rf_multiport: RTL and testbench
===============================

Name: rf_multiport

Overview:
- Parametrised multi-port register file; successor to the fixed 4-write/10-read core register file.
- Port counts, zero-register, instruction-pointer (IP) auto-advance and write-conflict detection are configurable.
- Sits in the core between the decode/issue stage (read addresses) and the execution units (write-back).
- Feeds operand buses A/B/C and the fetch unit via ip_o.

Parameters:
- WORD_WIDTH, 32, bits per register.
- ADDRESS_WIDTH, 5, register address bits; register count NREG = 2**ADDRESS_WIDTH.
- READ_PORTS, 10, number of independent read ports.
- WRITE_PORTS, 4, number of independent write ports.
- IP_OFFSET, 2, index of the register acting as IP.
- IP_STEP, 4, increment applied to IP on ip_advance_i.
- RESET_IP, 0, IP value after reset.
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- arst_ni  in  1  asynchronous reset, active low.
- rd_addr_i  in  [READ_PORTS][ADDRESS_WIDTH]  read addresses.
- rd_data_o  out  [READ_PORTS][WORD_WIDTH]  read data.
- wr_addr_i  in  [WRITE_PORTS][ADDRESS_WIDTH]  write addresses.
- wr_data_i  in  [WRITE_PORTS][WORD_WIDTH]  write data.
- wr_en_i  in  [WRITE_PORTS]  per-port write enable.
- ip_advance_i  in  1  advance IP by IP_STEP this cycle.
- ip_o  out  WORD_WIDTH  current IP register value.
- conflict_o  out  1  registered flag: previous cycle had at least two enabled write ports targeting the same address.

Behaviour:
- Reset (arst_ni low, asynchronous):
  - all registers become 0, except register IP_OFFSET, which becomes RESET_IP;
  - conflict_o becomes 0;
  - state stays held while arst_ni is low; the first update happens on the first rising edge after arst_ni goes high.
- Reads are combinational: rd_data_o[p] = reg[rd_addr_i[p]]. No read latency.
- With ZERO_REG=1, reads of address 0 always return 0.
- Writes take effect on the rising edge; new values are visible to reads in the following cycle.
- Multiple enabled ports to the same address: the highest-index port wins. Lower ports to that address are dropped.
- Ports writing different addresses all commit in the same cycle.
- conflict_o is set on the next edge when any pair of enabled ports shares an address, otherwise cleared.
  - A conflict on address 0 with ZERO_REG=1 is still flagged.
- ZERO_REG=1: writes to address 0 are discarded.
- ZERO_REG=1 together with IP_OFFSET=0 is an elaboration error, raised via $error in a generate check.
- IP_OFFSET >= NREG is an elaboration error.
- IP register update, per edge, in priority order:
  1. any enabled write to IP_OFFSET → winning write data;
  2. else ip_advance_i=1 → IP + IP_STEP, wrapping modulo 2**WORD_WIDTH;
  3. else hold.
- ip_o = reg[IP_OFFSET]; reads of IP_OFFSET through rd ports return the same value.
- All other registers hold unless written.
- X on wr_addr_i while the matching wr_en_i=0 must not corrupt state.

Optional Feature:
- Macro: RF_MULTIPORT_BYPASS_EN.
- Defined:
  - a read whose address matches an enabled write port in the same cycle returns that port's wr_data_i combinationally; highest enabled matching port wins;
  - address 0 with ZERO_REG=1 still returns 0;
  - for IP_OFFSET, the bypass returns write data only; ip_advance_i is not forwarded.
- Undefined: reads always return the pre-edge stored value, as described under Behaviour.

Test Plan:
1. Reset low → all rd_data_o = 0 and ip_o = RESET_IP (0), while clk_i toggles. Release reset, write ports 0..3 write addresses 4..7 with data 11,12,13,14 → next cycle rd ports reading 4..7 show 11,12,13,14 and conflict_o = 0.
2. Ports 1 and 3 both write address 9, data 0xAA and 0xBB → next cycle reg9 = 0xBB and conflict_o = 1; one idle cycle later conflict_o = 0.
3. ZERO_REG=1, port 0 writes address 0 with 0xFFFF_FFFF → read of address 0 returns 0 on both that cycle and the next.
4. ip_advance_i=1 for 3 cycles from RESET_IP=0 → ip_o = 4, 8, 12. Same cycle: ip_advance_i=1 and port 2 writes IP_OFFSET with 0x100 → ip_o = 0x100. IP = 0xFFFF_FFFC with advance → ip_o = 0.
5. Assert arst_ni low mid-stream with writes pending → outputs go to reset values immediately, without waiting for a clock edge; the write on the next edge during reset is ignored.
6. RF_MULTIPORT_BYPASS_EN defined, port 0 writes address 5 with 0x55 while rd port 3 reads address 5 → rd_data_o[3] = 0x55 in the same cycle. Undefined → old value in the same cycle, 0x55 the next cycle.

Source files
------------

// File: rtl/rf_multiport.sv
// Parametrised multi-port register file with zero-register, IP auto-advance and write-conflict flag.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_MULTIPORT_BYPASS_EN.
module rf_multiport #(
    parameter int unsigned          WORD_WIDTH    = 32,
    parameter int unsigned          ADDRESS_WIDTH = 5,
    parameter int unsigned          READ_PORTS    = 10,
    parameter int unsigned          WRITE_PORTS   = 4,
    parameter int unsigned          IP_OFFSET     = 2,
    parameter int unsigned          IP_STEP       = 4,
    parameter logic [WORD_WIDTH-1:0] RESET_IP     = '0,
    parameter bit                   ZERO_REG      = 1'b1
) (
    input  logic                                        clk_i,
    input  logic                                        arst_ni,
    input  logic [READ_PORTS-1:0][ADDRESS_WIDTH-1:0]    rd_addr_i,
    output logic [READ_PORTS-1:0][WORD_WIDTH-1:0]       rd_data_o,
    input  logic [WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0]   wr_addr_i,
    input  logic [WRITE_PORTS-1:0][WORD_WIDTH-1:0]      wr_data_i,
    input  logic [WRITE_PORTS-1:0]                      wr_en_i,
    input  logic                                        ip_advance_i,
    output logic [WORD_WIDTH-1:0]                       ip_o,
    output logic                                        conflict_o
);

    localparam int unsigned NREG = 2 ** ADDRESS_WIDTH;

    if (ZERO_REG && (IP_OFFSET == 0)) begin : g_err_ip_zero
        $error("rf_multiport: IP_OFFSET must not be 0 when ZERO_REG is set");
    end
    if (IP_OFFSET >= NREG) begin : g_err_ip_range
        $error("rf_multiport: IP_OFFSET out of register range");
    end

    logic [WORD_WIDTH-1:0] regs [NREG];
    logic                  conflict_c;

    // Per-register storage; the highest-index enabled port to an address wins.
    for (genvar r = 0; r < NREG; r++) begin : g_reg
        if (ZERO_REG && (r == 0)) begin : g_zero
            assign regs[r] = '0;
        end else begin : g_store
            localparam bit IS_IP = (r == IP_OFFSET);
            logic                  hit;
            logic [WORD_WIDTH-1:0] val;
            logic [WORD_WIDTH-1:0] q;

            always_comb begin
                hit = 1'b0;
                val = '0;
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    if (wr_en_i[p] && (wr_addr_i[p] == ADDRESS_WIDTH'(r))) begin
                        hit = 1'b1;
                        val = wr_data_i[p];
                    end
                end
            end

            always_ff @(posedge clk_i or negedge arst_ni) begin
                if (!arst_ni) begin
                    q <= IS_IP ? RESET_IP : '0;
                end else if (hit) begin
                    q <= val;
                end else if (IS_IP && ip_advance_i) begin
                    q <= q + WORD_WIDTH'(IP_STEP);
                end
            end

            assign regs[r] = q;
        end
    end

    assign ip_o = regs[IP_OFFSET];

    // Any pair of enabled ports sharing an address, including address 0.
    always_comb begin
        conflict_c = 1'b0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            for (int q = p + 1; q < WRITE_PORTS; q++) begin
                if (wr_en_i[p] && wr_en_i[q] && (wr_addr_i[p] == wr_addr_i[q])) begin
                    conflict_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            conflict_o <= 1'b0;
        end else begin
            conflict_o <= conflict_c;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_data_o[p] = regs[rd_addr_i[p]];
`ifdef RF_MULTIPORT_BYPASS_EN
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w] == rd_addr_i[p])) begin
                    rd_data_o[p] = wr_data_i[w];
                end
            end
`endif
            if (ZERO_REG && (rd_addr_i[p] == '0)) begin
                rd_data_o[p] = '0;
            end
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Randomised self-checking bench for rf_multiport against an array-based reference model.
module tb_rf_multiport;

    localparam int unsigned WW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned RP   = 10;
    localparam int unsigned WP   = 4;
    localparam int unsigned IPO  = 2;
    localparam int unsigned NREG = 32;

    logic                    clk_i;
    logic                    arst_ni;
    logic [RP-1:0][AW-1:0]   rd_addr;
    logic [RP-1:0][WW-1:0]   rd_data;
    logic [WP-1:0][AW-1:0]   wr_addr;
    logic [WP-1:0][WW-1:0]   wr_data;
    logic [WP-1:0]           wr_en;
    logic                    ip_adv;
    logic [WW-1:0]           ip;
    logic                    conflict;

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] model_q [NREG];
    bit            model_conf;

    rf_multiport dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .wr_en_i      (wr_en),
        .ip_advance_i (ip_adv),
        .ip_o         (ip),
        .conflict_o   (conflict)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) model_q[r] = '0;
        model_q[IPO] = '0;
        model_conf   = 1'b0;
    endtask

    // Register-file semantics: later (higher) ports overwrite earlier ones, address 0 discards.
    task automatic model_update();
        logic [WW-1:0] nxt [NREG];
        int            cnt [NREG];
        bit            ip_written;
        bit            conf;
        if (!arst_ni) begin
            model_reset();
            return;
        end
        nxt        = model_q;
        cnt        = '{default: 0};
        ip_written = 1'b0;
        conf       = 1'b0;
        for (int p = 0; p < WP; p++) begin
            if (wr_en[p]) begin
                cnt[wr_addr[p]]++;
                if (cnt[wr_addr[p]] > 1) conf = 1'b1;
                if (int'(wr_addr[p]) == IPO) ip_written = 1'b1;
                if (wr_addr[p] != '0) nxt[wr_addr[p]] = wr_data[p];
            end
        end
        if (!ip_written && ip_adv) nxt[IPO] = model_q[IPO] + 32'd4;
        model_q    = nxt;
        model_conf = conf;
    endtask

    function automatic logic [WW-1:0] exp_read(input logic [AW-1:0] a);
        logic [WW-1:0] v;
        v = model_q[a];
`ifdef RF_MULTIPORT_BYPASS_EN
        for (int w = 0; w < WP; w++) begin
            if (wr_en[w] && wr_addr[w] == a) v = wr_data[w];
        end
`endif
        if (a == '0) v = '0;
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        for (int p = 0; p < RP; p++) begin
            check($sformatf("%s rd%0d", tag, p), rd_data[p], exp_read(rd_addr[p]));
        end
        check({tag, " ip"}, ip, model_q[IPO]);
        check({tag, " conflict"}, 32'(conflict), 32'(model_conf));
    endtask

    // Check same-cycle view mid-period, then advance one edge and update the model.
    task automatic cycle(input string tag);
        @(negedge clk_i);
        check_outputs(tag);
        @(posedge clk_i);
        #1;
        model_update();
    endtask

    task automatic idle();
        wr_en  = '0;
        ip_adv = 1'b0;
        for (int p = 0; p < WP; p++) begin
            wr_addr[p] = AW'(p);
            wr_data[p] = '0;
        end
        for (int p = 0; p < RP; p++) rd_addr[p] = AW'($urandom_range(0, NREG - 1));
    endtask

    task automatic randomize_inputs();
        for (int p = 0; p < WP; p++) begin
            wr_en[p]   = ($urandom_range(0, 2) != 0);
            wr_data[p] = $urandom;
            if (!wr_en[p])                         wr_addr[p] = 'x;
            else if ($urandom_range(0, 3) == 0)    wr_addr[p] = AW'($urandom_range(0, 3));
            else                                   wr_addr[p] = AW'($urandom_range(0, NREG - 1));
        end
        for (int p = 0; p < RP; p++) rd_addr[p] = AW'($urandom_range(0, NREG - 1));
        ip_adv = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        arst_ni = 1'b0;
        idle();
        #1;
        model_reset();
        check_outputs("reset");
        cycle("reset_hold");
        cycle("reset_hold");
        arst_ni = 1'b1;

        // Four distinct-address writes in one cycle.
        for (int p = 0; p < WP; p++) begin
            wr_en[p]   = 1'b1;
            wr_addr[p] = AW'(4 + p);
            wr_data[p] = WW'(11 + p);
        end
        cycle("t1_wr");
        idle();
        for (int p = 0; p < WP; p++) rd_addr[p] = AW'(4 + p);
        #1;
        for (int p = 0; p < WP; p++) check($sformatf("t1 reg%0d", 4 + p), rd_data[p], WW'(11 + p));
        check("t1 conflict", 32'(conflict), 32'd0);
        cycle("t1_rd");

        // Two ports to the same address: highest index wins, conflict flagged for one cycle.
        wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'hAA;
        wr_en[3] = 1'b1; wr_addr[3] = 5'd9; wr_data[3] = 32'hBB;
        cycle("t2_wr");
        idle();
        rd_addr[0] = 5'd9;
        #1;
        check("t2 reg9", rd_data[0], 32'hBB);
        check("t2 conflict set", 32'(conflict), 32'd1);
        cycle("t2_rd");
        check("t2 conflict clear", 32'(conflict), 32'd0);

        // Writes to register 0 are discarded.
        wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF_FFFF;
        rd_addr[0] = 5'd0;
        #1;
        check("t3 zero same", rd_data[0], 32'd0);
        cycle("t3_wr");
        idle();
        rd_addr[0] = 5'd0;
        #1;
        check("t3 zero next", rd_data[0], 32'd0);

        // IP advance, write priority over advance, wrap-around.
        ip_adv = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycle("t4_adv");
            check($sformatf("t4 ip step%0d", k), ip, WW'(4 * k));
        end
        wr_en[2] = 1'b1; wr_addr[2] = AW'(IPO); wr_data[2] = 32'h100;
        cycle("t4_wr_adv");
        check("t4 ip write wins", ip, 32'h100);
        idle();
        wr_en[0] = 1'b1; wr_addr[0] = AW'(IPO); wr_data[0] = 32'hFFFF_FFFC;
        cycle("t4_wr_top");
        idle();
        ip_adv = 1'b1;
        cycle("t4_wrap");
        check("t4 ip wrap", ip, 32'd0);

        // Same-cycle read of an address being written.
        idle();
        wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'h55;
        rd_addr[3] = 5'd5;
        #1;
`ifdef RF_MULTIPORT_BYPASS_EN
        check("t6 same cycle", rd_data[3], 32'h55);
`else
        check("t6 same cycle", rd_data[3], 32'd12);
`endif
        cycle("t6_wr");
        idle();
        rd_addr[3] = 5'd5;
        #1;
        check("t6 next cycle", rd_data[3], 32'h55);

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            cycle("rand");
        end

        // Asynchronous reset with writes pending.
        randomize_inputs();
        for (int p = 0; p < WP; p++) begin
            wr_en[p]   = 1'b1;
            wr_addr[p] = AW'(IPO + p);
        end
        #2;
        arst_ni = 1'b0;
        #1;
        model_reset();
        check("t5 ip async", ip, 32'd0);
        check("t5 conflict async", 32'(conflict), 32'd0);
        check_outputs("t5_async");
        cycle("t5_edge_in_reset");
        check("t5 ip held", ip, 32'd0);
        arst_ni = 1'b1;

        for (int i = 0; i < 200; i++) begin
            randomize_inputs();
            cycle("rand2");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
